vga_pixgen: RTL and testbench



---
 rtl/vga_pixgen.sv | 129 ++++++++++++
 tb/tb_vga_pixgen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vga_pixgen.sv
// VGA raster timing generator and FIFO word unpacker for the pixel-clock domain.
// Pops FWFT FIFO words during active video and shifts them out MSB-first as pixels.
module vga_pixgen #(
  parameter int BUSW = 32,
  parameter int BPP  = 8,
  parameter int HW   = 12
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_en,
  input  logic [HW-1:0]   i_hm,
  input  logic [HW-1:0]   i_hs,
  input  logic [HW-1:0]   i_he,
  input  logic [HW-1:0]   i_ht,
  input  logic [HW-1:0]   i_vm,
  input  logic [HW-1:0]   i_vs,
  input  logic [HW-1:0]   i_ve,
  input  logic [HW-1:0]   i_vt,
  input  logic            i_valid,
  input  logic [BUSW-1:0] i_word,
  output logic            o_rd,
  output logic            o_newframe,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_de,
  output logic [BPP-1:0]  o_pixel,
  output logic            o_underflow,
  output logic            o_err
);

  localparam int PPW = BUSW / BPP;
  localparam int PCW = (PPW > 1) ? $clog2(PPW) : 1;

  logic [HW-1:0]   hpos_q, hpos_d, vpos_q, vpos_d;
  logic [PCW-1:0]  pcount_q, pcount_d;
  logic [BUSW-1:0] shreg_q, shreg_d;
  logic [BUSW-1:0] word;
  logic [BPP-1:0]  pixel_q, pixel_d;
  logic            de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic            newframe_q, newframe_d, underflow_q, underflow_d, err_q, err_d;
  logic            active, fetch, hwrap;

  always_comb begin
    hwrap  = (hpos_q == i_ht - HW'(1));
    active = (hpos_q < i_hm) && (vpos_q < i_vm);
    fetch  = active && (pcount_q == '0);
    o_rd   = !i_reset && i_en && fetch && i_valid;

    hpos_d      = '0;
    vpos_d      = '0;
    pcount_d    = '0;
    shreg_d     = '0;
    word        = '0;
    pixel_d     = '0;
    de_d        = 1'b0;
    hsync_d     = 1'b1;
    vsync_d     = 1'b1;
    newframe_d  = 1'b0;
    underflow_d = 1'b0;
    err_d       = err_q;

    if (i_en) begin
      hpos_d   = hwrap ? '0 : hpos_q + HW'(1);
      vpos_d   = vpos_q;
      if (hwrap)
        vpos_d = (vpos_q == i_vt - HW'(1)) ? '0 : vpos_q + HW'(1);
      pcount_d = pcount_q;
      shreg_d  = shreg_q;

      if (active) begin
        // A missed word is unpacked as zeros so pixel alignment within the line survives.
        if (fetch) begin
          word        = i_valid ? i_word : '0;
          underflow_d = !i_valid;
        end else begin
          word        = shreg_q;
        end
        pixel_d  = word[BUSW-1 -: BPP];
        shreg_d  = word << BPP;
        pcount_d = (pcount_q == PCW'(PPW - 1)) ? '0 : pcount_q + PCW'(1);
      end
      if (hpos_d == '0)
        pcount_d = '0;

      de_d       = active;
      hsync_d    = !((hpos_q >= i_hs) && (hpos_q < i_he));
      vsync_d    = !((vpos_q >= i_vs) && (vpos_q < i_ve));
      newframe_d = (hpos_q == '0) && (vpos_q == i_vm);
      err_d      = newframe_d ? underflow_d : (err_q | underflow_d);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hpos_q      <= '0;
      vpos_q      <= '0;
      pcount_q    <= '0;
      shreg_q     <= '0;
      pixel_q     <= '0;
      de_q        <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      newframe_q  <= 1'b0;
      underflow_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      pcount_q    <= pcount_d;
      shreg_q     <= shreg_d;
      pixel_q     <= pixel_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      newframe_q  <= newframe_d;
      underflow_q <= underflow_d;
      err_q       <= err_d;
    end
  end

  assign o_pixel     = pixel_q;
  assign o_de        = de_q;
  assign o_hsync     = hsync_q;
  assign o_vsync     = vsync_q;
  assign o_newframe  = newframe_q;
  assign o_underflow = underflow_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_vga_pixgen.sv
// Directed bench for vga_pixgen: a position-based raster model checked every cycle,
// plus literal expectations on pixel order, pop counts, sync widths and frame period.
module tb_vga_pixgen;

  localparam int HM = 8, HS = 10, HE = 12, HT = 14;
  localparam int VM = 4, VS = 5, VE = 6, VT = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1, en = 1'b0, valid = 1'b0;
  logic [31:0] word = '0;
  logic        o_rd, o_newframe, o_hsync, o_vsync, o_de, o_underflow, o_err;
  logic [7:0]  o_pixel;

  vga_pixgen #(.BUSW(32), .BPP(8), .HW(12)) dut (
    .i_clk(clk), .i_reset(reset), .i_en(en),
    .i_hm(12'd8), .i_hs(12'd10), .i_he(12'd12), .i_ht(12'd14),
    .i_vm(12'd4), .i_vs(12'd5), .i_ve(12'd6), .i_vt(12'd7),
    .i_valid(valid), .i_word(word), .o_rd(o_rd), .o_newframe(o_newframe),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de), .o_pixel(o_pixel),
    .o_underflow(o_underflow), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;
  int mh = 0, mv = 0;
  logic [31:0] fword = '0;
  logic exp_de = 0, exp_hs = 1, exp_vs = 1, exp_nf = 0, exp_uf = 0, exp_err = 0, exp_rd;
  logic [7:0] exp_pix = '0;
  logic wmode = 1'b0;

  int rd_cnt, hs_low, vs_low, nf_cnt, nf_last, nf_prev, uf_cnt, pix_n, first_de;
  logic [7:0] pix_rec[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d pos=(%0d,%0d) got=%h want=%h", name, cyc, mh, mv, act, exp);
    end
  endtask

  function automatic logic [31:0] wv();
    if (!wmode) return 32'h11223344;
    return 32'hA0B0C0D0 | (32'(mv) << 24) | (32'(mh / 4) << 16) | (32'(mv) << 8) | 32'(mh / 4);
  endfunction

  // One clock: drive inputs at negedge, compare, then advance the model at posedge.
  task automatic step(input logic r, input logic e, input logic v, input logic [31:0] w);
    logic act;
    @(negedge clk);
    reset = r; en = e; valid = v; word = w;
    #1;
    if (r) begin
      mh = 0; mv = 0;
      exp_de = 0; exp_hs = 1; exp_vs = 1; exp_pix = '0; exp_nf = 0; exp_uf = 0; exp_err = 0;
    end
    exp_rd = !r && e && v && (mh < HM) && (mv < VM) && (mh % 4 == 0);
    chk("de", o_de, exp_de);
    chk("hsync", o_hsync, exp_hs);
    chk("vsync", o_vsync, exp_vs);
    chk("pixel", o_pixel, exp_pix);
    chk("newframe", o_newframe, exp_nf);
    chk("underflow", o_underflow, exp_uf);
    chk("err", o_err, exp_err);
    chk("rd", o_rd, exp_rd);
    if (o_rd) rd_cnt++;
    if (!o_hsync) hs_low++;
    if (!o_vsync) vs_low++;
    if (o_underflow) uf_cnt++;
    if (o_newframe) begin nf_cnt++; nf_prev = nf_last; nf_last = cyc; end
    if (o_de && pix_n < 8) begin pix_rec[pix_n] = o_pixel; pix_n++; end
    if (o_de && first_de < 0) first_de = cyc;
    @(posedge clk);
    cyc++;
    if (!r) begin
      if (!e) begin
        mh = 0; mv = 0;
        exp_de = 0; exp_hs = 1; exp_vs = 1; exp_pix = '0; exp_nf = 0; exp_uf = 0;
      end else begin
        act = (mh < HM) && (mv < VM);
        if (act && mh % 4 == 0) fword = v ? w : 32'h0;
        exp_de  = act;
        exp_pix = act ? 8'(fword >> (24 - 8 * (mh % 4))) : 8'h00;
        exp_hs  = !(mh >= HS && mh < HE);
        exp_vs  = !(mv >= VS && mv < VE);
        exp_nf  = (mh == 0) && (mv == VM);
        exp_uf  = act && (mh % 4 == 0) && !v;
        exp_err = exp_nf ? exp_uf : (exp_err | exp_uf);
        mh++;
        if (mh == HT) begin mh = 0; mv = (mv + 1) % VT; end
      end
    end
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 400 && !(mh == h && mv == v); i++) step(0, 1, 1, wv());
    if (!(mh == h && mv == v)) begin
      miscompares++;
      $display("FAIL reach got=(%0d,%0d) want=(%0d,%0d)", mh, mv, h, v);
    end
  endtask

  initial begin
    logic [7:0] lit[8];
    lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
    rd_cnt = 0; hs_low = 0; vs_low = 0; nf_cnt = 0; nf_last = 0; nf_prev = 0;
    uf_cnt = 0; pix_n = 0; first_de = -1;

    // Reset state, then one disabled cycle.
    for (int i = 0; i < 3; i++) step(1, 0, 1, wv());
    step(0, 0, 1, wv());

    // Constant word: pixel order, pops, sync widths over exactly one frame.
    rd_cnt = 0; hs_low = 0; vs_low = 0; pix_n = 0; nf_cnt = 0;
    for (int i = 0; i < 98; i++) step(0, 1, 1, wv());
    for (int i = 0; i < 8; i++) chk("line0_pix", pix_rec[i], lit[i]);
    chk("pops_per_frame", rd_cnt, 8);
    chk("hsync_low_clks", hs_low, 14);
    chk("vsync_low_clks", vs_low, 14);
    chk("nf_frame0", nf_cnt, 1);

    // Frame pulse period.
    nf_cnt = 0;
    for (int i = 0; i < 196; i++) step(0, 1, 1, wv());
    chk("nf_count", nf_cnt, 2);
    chk("nf_period", nf_last - nf_prev, 98);

    // Underflow at the hpos=4 read of line 1, with position-dependent words.
    wmode = 1'b1;
    run_to(4, 1);
    uf_cnt = 0;
    step(0, 1, 0, wv());
    run_to(0, 3);
    chk("err_held", o_err, 1);
    run_to(0, 5);
    chk("uf_pulses", uf_cnt, 1);
    chk("err_cleared", o_err, 0);

    // Reset at hpos=3 of line 2.
    run_to(3, 2);
    step(1, 1, 1, wv());
    chk("rst_de", o_de, 0);
    chk("rst_pix", o_pixel, 0);
    step(1, 0, 1, wv());
    step(0, 0, 1, wv());
    first_de = -1;
    begin
      int en_cyc;
      en_cyc = cyc;
      for (int i = 0; i < 4; i++) step(0, 1, 1, wv());
      chk("first_de_lat", first_de - en_cyc, 1);
    end

    // Create an error, then disable mid-frame for 20 clocks.
    run_to(0, 1);
    step(0, 1, 0, wv());
    run_to(5, 2);
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) step(0, 0, 1, wv());
    chk("rd_while_off", rd_cnt, 0);
    chk("err_hold_off", o_err, 1);
    for (int i = 0; i < 110; i++) step(0, 1, 1, wv());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
